cby_param_ccff: RTL

// - Parametrised Y-direction connection block: CHAN_WIDTH bidirectional track pass-through plus NUM_IPIN
//   MUX_SIZE:1 input-pin muxes into the left grid.
// - Mux selects are held in a double-buffered configuration chain: bits shift into a shadow register, and a

---
 rtl/cby_pkg.sv | 18 +
 rtl/cby_ccff_chain.sv | 94 +++++++++
 rtl/cby_param_ccff.sv | 74 +++++++
 3 files changed

// File: rtl/cby_pkg.sv
// rtl/cby_pkg.sv - shared types and elaboration helpers for the Y connection block.
package cby_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2
  } ccff_state_t;

  function automatic int sel_width(input int mux_size);
    return (mux_size > 1) ? $clog2(mux_size) : 1;
  endfunction

  function automatic int track_idx(input int i, input int p, input int stride, input int width);
    return (i + p * stride) % width;
  endfunction

endpackage

// File: rtl/cby_ccff_chain.sv
// rtl/cby_ccff_chain.sv - double-buffered configuration chain (shadow/active, counter, FSM).
// Optional readback path under CBY_CFG_READBACK_EN.
module cby_ccff_chain #(
  parameter int CFG_BITS = 16
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
`ifdef CBY_CFG_READBACK_EN
  input  logic                ccff_readback,
`endif
  output logic                ccff_tail,
  output logic [CFG_BITS-1:0] active,
  output logic                cfg_valid,
  output logic                cfg_err
);
  import cby_pkg::*;

  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CW-1:0]       count_q, count_d;
  ccff_state_t         state_q, state_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_err_q, cfg_err_d;
  logic                commit_ok;

  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    count_d     = count_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    commit_ok   = ccff_commit && !ccff_shift_en && (state_q == FULL);

    // Shifting proceeds even alongside an illegal commit/readback.
    if (ccff_shift_en) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
      if (count_q != FULL_CNT) count_d = count_q + 1'b1;
    end

    if (ccff_commit) begin
      if (commit_ok) begin
        active_d    = shadow_q;
        cfg_valid_d = 1'b1;
        count_d     = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
`ifdef CBY_CFG_READBACK_EN
    else if (ccff_readback) begin
      if (ccff_shift_en) begin
        cfg_err_d = 1'b1;
      end else begin
        shadow_d = active_q;
        count_d  = '0;
      end
    end
`endif

    if (count_d == '0)          state_d = EMPTY;
    else if (count_d == FULL_CNT) state_d = FULL;
    else                        state_d = LOAD;
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      count_q     <= '0;
      state_q     <= EMPTY;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ccff_tail = shadow_q[CFG_BITS-1];
  assign active    = active_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/cby_param_ccff.sv
// rtl/cby_param_ccff.sv - Y connection block: track pass-through plus configurable input-pin muxes.
// Optional configuration readback port under CBY_CFG_READBACK_EN.
module cby_param_ccff #(
  parameter int CHAN_WIDTH   = 30,
  parameter int NUM_IPIN     = 4,
  parameter int MUX_SIZE     = 12,
  parameter int TRACK_STRIDE = 3
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  ccff_head,
  input  logic                  ccff_shift_en,
  input  logic                  ccff_commit,
`ifdef CBY_CFG_READBACK_EN
  input  logic                  ccff_readback,
`endif
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  output logic                  ccff_tail,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  cfg_valid,
  output logic                  cfg_err
);
  import cby_pkg::*;

  localparam int SEL_W    = sel_width(MUX_SIZE);
  localparam int CFG_BITS = NUM_IPIN * SEL_W;

  logic [CFG_BITS-1:0] active;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  cby_ccff_chain #(.CFG_BITS(CFG_BITS)) u_chain (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_commit   (ccff_commit),
`ifdef CBY_CFG_READBACK_EN
    .ccff_readback (ccff_readback),
`endif
    .ccff_tail     (ccff_tail),
    .active        (active),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err)
  );

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [SEL_W-1:0]        sel;
    logic [(1<<SEL_W)-1:0]   mux_in;

    assign sel = active[i*SEL_W +: SEL_W];

    // Unused select codes are tied low so out-of-range selects read as 0.
    for (genvar k = 0; k < (1 << SEL_W); k++) begin : g_in
      if (k < MUX_SIZE) begin : g_used
        localparam int T = track_idx(i, k / 2, TRACK_STRIDE, CHAN_WIDTH);
        if (k % 2 == 0) begin : g_bot
          assign mux_in[k] = chany_bottom_in[T];
        end else begin : g_top
          assign mux_in[k] = chany_top_in[T];
        end
      end else begin : g_unused
        assign mux_in[k] = 1'b0;
      end
    end

    assign ipin_out[i] = cfg_valid & mux_in[sel];
  end

endmodule
